sw_conditioner: RTL and testbench

- Input-conditioning stage that sits directly upstream of the switch-driven multiplexer logic on the DE1-SoC/DE0-CV.
- Synchronizes the 10 raw slide switches to CLOCK_50 and debounces each bit independently.
- Presents clean, stable switch levels (select in bit 9, X in [3:0], Y in [7:4]), plus per-bit edge pulses and a change strobe, to the downstream mux stage.

---
 rtl/sw_conditioner.sv | 50 +++++
 tb/tb_sw_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sw_conditioner.sv
// sw_conditioner: two-flop synchronizer and per-bit debouncer for the slide switches, with edge pulses.
// Optional SWCOND_CHG_COUNT_EN builds an 8-bit accepted-change counter on CHG_COUNT.
module sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [9:0] SW,
    output logic [9:0] SW_CLEAN,
    output logic [9:0] SW_RISE,
    output logic [9:0] SW_FALL,
    output logic       SW_CHANGED,
    output logic [7:0] CHG_COUNT
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [9:0] sync1, sync2, accept;
    genvar b;
    for (b = 0; b < 10; b++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        assign accept[b] = (sync2[b] != SW_CLEAN[b]) && (cnt == LAST);
        always_ff @(posedge CLOCK_50 or negedge RESET_N)
            if (!RESET_N) cnt <= '0;
            else cnt <= (sync2[b] == SW_CLEAN[b] || accept[b]) ? '0 : cnt + CNT_W'(1);
    end
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            sync1      <= '0;
            sync2      <= '0;
            SW_CLEAN   <= '0;
            SW_RISE    <= '0;
            SW_FALL    <= '0;
            SW_CHANGED <= 1'b0;
        end else begin
            sync1      <= SW;
            sync2      <= sync1;
            SW_CLEAN   <= SW_CLEAN ^ accept;
            SW_RISE    <= accept & sync2;
            SW_FALL    <= accept & ~sync2;
            SW_CHANGED <= |accept;
        end
`ifdef SWCOND_CHG_COUNT_EN
    // Counts alongside SW_CHANGED so both become visible in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) CHG_COUNT <= '0;
        else CHG_COUNT <= CHG_COUNT + {7'd0, |accept};
`else
    assign CHG_COUNT = 8'd0;
`endif
endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: directed table and sequence checks of sw_conditioner with DEBOUNCE_CYCLES=4.
module tb_sw_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw = '0;
    logic [9:0] clean, rise, fall;
    logic       chg;
    logic [7:0] cc;
    int errors = 0;
    int checks = 0;
    int exp_cc = 0;

    sw_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw),
        .SW_CLEAN(clean), .SW_RISE(rise), .SW_FALL(fall),
        .SW_CHANGED(chg), .CHG_COUNT(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        int         edges;
        logic [9:0] clean;
        logic [9:0] rise;
        logic [9:0] fall;
        logic       chg;
        logic [7:0] cc;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [7:0] ecc(input int v);
`ifdef SWCOND_CHG_COUNT_EN
        return 8'(v);
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] c, input logic [9:0] r,
                           input logic [9:0] f, input logic g, input logic [7:0] n);
        chk({tag, ".clean"}, 32'(clean), 32'(c));
        chk({tag, ".rise"}, 32'(rise), 32'(r));
        chk({tag, ".fall"}, 32'(fall), 32'(f));
        chk({tag, ".chg"}, 32'(chg), 32'(g));
        chk({tag, ".cnt"}, 32'(cc), 32'(n));
    endtask

    initial begin
        int nrise, nfall, at_edge, nchg;
        tbl[0] = '{10'h2A5, 5, 10'h000, 10'h000, 10'h000, 1'b0, 8'd0};
        tbl[1] = '{10'h2A5, 1, 10'h2A5, 10'h2A5, 10'h000, 1'b1, 8'd1};
        tbl[2] = '{10'h2A5, 1, 10'h2A5, 10'h000, 10'h000, 1'b0, 8'd1};
        tbl[3] = '{10'h15A, 5, 10'h2A5, 10'h000, 10'h000, 1'b0, 8'd1};
        tbl[4] = '{10'h15A, 1, 10'h15A, 10'h15A, 10'h2A5, 1'b1, 8'd2};
        tbl[5] = '{10'h15A, 1, 10'h15A, 10'h000, 10'h000, 1'b0, 8'd2};
        tbl[6] = '{10'h3FF, 6, 10'h3FF, 10'h2A5, 10'h000, 1'b1, 8'd3};
        tbl[7] = '{10'h000, 6, 10'h000, 10'h000, 10'h3FF, 1'b1, 8'd4};
        tbl[8] = '{10'h000, 1, 10'h000, 10'h000, 10'h000, 1'b0, 8'd4};

        repeat (2) tick;
        chk_all("reset", 10'h000, 10'h000, 10'h000, 1'b0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            sw = tbl[i].sw;
            repeat (tbl[i].edges) tick;
            chk_all($sformatf("vec%0d", i), tbl[i].clean, tbl[i].rise, tbl[i].fall,
                    tbl[i].chg, ecc(int'(tbl[i].cc)));
        end
        exp_cc = 4;

        // Async reset while a pulse is live and a fresh change is pending.
        sw = 10'h3FF;
        repeat (6) tick;
        exp_cc++;
        chk_all("pre_rst", 10'h3FF, 10'h3FF, 10'h000, 1'b1, ecc(exp_cc));
        sw = 10'h000;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 10'h000, 10'h000, 10'h000, 1'b0, 8'd0);
        exp_cc = 0;
        repeat (2) tick;
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick;
            chk_all("post_rst", 10'h000, 10'h000, 10'h000, 1'b0, 8'd0);
        end

        // A 3-cycle blip on bit 9 is one cycle short of acceptance.
        sw = 10'h200;
        for (int e = 0; e < 3; e++) begin
            tick;
            chk_all("glitch_hi", 10'h000, 10'h000, 10'h000, 1'b0, 8'd0);
        end
        sw = 10'h000;
        for (int e = 0; e < 10; e++) begin
            tick;
            chk_all("glitch_lo", 10'h000, 10'h000, 10'h000, 1'b0, 8'd0);
        end

        // Bounce on bit 0, then settle high.
        nrise = 0;
        nfall = 0;
        at_edge = 0;
        for (int k = 0; k < 4; k++) begin
            sw = (k % 2 == 0) ? 10'h001 : 10'h000;
            repeat (2) begin
                tick;
                nrise += int'(rise[0]);
                nfall += int'(fall[0]);
            end
        end
        sw = 10'h001;
        for (int e = 1; e <= 12; e++) begin
            tick;
            if (rise[0]) begin
                nrise++;
                at_edge = e;
            end
            nfall += int'(fall[0]);
        end
        exp_cc++;
        chk("bounce_nrise", 32'(nrise), 32'd1);
        chk("bounce_edge", 32'(at_edge), 32'd6);
        chk("bounce_nfall", 32'(nfall), 32'd0);
        chk("bounce_clean", 32'(clean), 32'h001);
        chk("bounce_cnt", 32'(cc), 32'(ecc(exp_cc)));

        // 256 accepted changes on bit 1 walk the counter through 255 -> 0.
        nchg = 0;
        for (int t = 0; t < 256; t++) begin
            sw = sw ^ 10'h002;
            for (int e = 0; e < 7; e++) begin
                tick;
                if (chg) begin
                    nchg++;
                    exp_cc = (exp_cc + 1) % 256;
                    chk("wrap_cnt", 32'(cc), 32'(ecc(exp_cc)));
                    chk("wrap_clean", 32'(clean), 32'(sw));
                end
            end
        end
        chk("wrap_nchg", 32'(nchg), 32'd256);
        chk("wrap_final_clean", 32'(clean), 32'h001);
        chk("wrap_final_cnt", 32'(cc), 32'(ecc(exp_cc)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
